// File: rtl/imm_decoder_pipe.sv
// imm_decoder_pipe: RISC-V immediate extraction and extension with a registered
// valid/ready output stage. The output register plus one skid register give two
// entries of buffering, so ready_o comes from a flop and never depends
// combinationally on ready_i.
module imm_decoder_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     inst_i,
    input  logic            auto_i,
    input  logic [2:0]      ImmSel_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    // Format-select encodings shared with the core's define.sv.
    localparam logic [2:0] I_TYPE = 3'd0;
    localparam logic [2:0] S_TYPE = 3'd1;
    localparam logic [2:0] B_TYPE = 3'd2;
    localparam logic [2:0] J_TYPE = 3'd3;
    localparam logic [2:0] U_TYPE = 3'd4;

    // Internal format, a superset of ImmSel_i covering the auto-only cases.
    typedef enum logic [2:0] {
        FMT_ZERO,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_SHAMT,
        FMT_ZIMM
    } fmt_e;

    fmt_e            fmt;
    logic            dec_illegal;
    logic [5:0]      shamt;
    logic [XLEN-1:0] dec_imm;

    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic            skid_illegal;

    logic            accept;
    logic            advance;

    // Pick the immediate format: from ImmSel_i in manual mode, from the opcode in auto mode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        fmt         = FMT_ZERO;
        dec_illegal = 1'b0;
        if (auto_i) begin
            case (inst_i[6:0])
                7'b0000011, 7'b1100111: fmt = FMT_I;
                7'b0010011: begin
                    // funct3 001 (slli) and 101 (srli/srai) are the only ones with [13:12]=01.
                    if (inst_i[13:12] == 2'b01) fmt = FMT_SHAMT;
                    else                        fmt = FMT_I;
                end
                7'b0100011:             fmt = FMT_S;
                7'b1100011:             fmt = FMT_B;
                7'b1101111:             fmt = FMT_J;
                7'b0110111, 7'b0010111: fmt = FMT_U;
                7'b1110011: begin
                    // CSR immediate forms carry zimm in the rs1 field.
                    if (inst_i[14]) fmt = FMT_ZIMM;
                    else            fmt = FMT_ZERO;
                end
                7'b0110011, 7'b0001111: fmt = FMT_ZERO;
                default:                dec_illegal = 1'b1;
            endcase
        end else begin
            case (ImmSel_i)
                I_TYPE:  fmt = FMT_I;
                S_TYPE:  fmt = FMT_S;
                B_TYPE:  fmt = FMT_B;
                J_TYPE:  fmt = FMT_J;
                U_TYPE:  fmt = FMT_U;
                default: fmt = FMT_ZERO;
            endcase
        end
    end

    // Assemble and extend the immediate for the selected format.
    always_comb begin
        // RV64 shift amounts use one more bit of the instruction than RV32.
        shamt   = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
        dec_imm = '0;
        case (fmt)
            FMT_I:     dec_imm = XLEN'($signed(inst_i[31:20]));
            FMT_S:     dec_imm = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
            FMT_B:     dec_imm = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                                inst_i[11:8], 1'b0}));
            FMT_J:     dec_imm = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                                inst_i[30:21], 1'b0}));
            FMT_U:     dec_imm = XLEN'($signed({inst_i[31:12], 12'b0}));
            FMT_SHAMT: dec_imm = XLEN'(shamt);
            FMT_ZIMM:  dec_imm = XLEN'(inst_i[19:15]);
            default:   dec_imm = '0;
        endcase
    end

    // Accept only while the skid slot is free; the output slot may move when empty or drained.
    assign ready_o = ~skid_valid;
    assign accept  = valid_i && ready_o;
    assign advance = !valid_o || ready_i;

    // Output stage and skid occupancy: reset beats flush, flush beats any movement.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            valid_o    <= 1'b0;
            imm_o      <= '0;
            illegal_o  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            imm_o      <= '0;
            illegal_o  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (advance) begin
            if (skid_valid) begin
                // ready_o was low, so no input competes with the skid entry here.
                valid_o    <= 1'b1;
                imm_o      <= skid_imm;
                illegal_o  <= skid_illegal;
                skid_valid <= 1'b0;
            end else if (accept) begin
                valid_o   <= 1'b1;
                imm_o     <= dec_imm;
                illegal_o <= dec_illegal;
            end else begin
                valid_o   <= 1'b0;
                imm_o     <= '0;
                illegal_o <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    // Skid payload captures an input that arrives while the output is stalled.
    always_ff @(posedge clk_i) begin
        // NOTE: payload registers are not reset; skid_valid alone qualifies their contents.
        if (accept && !advance) begin
            skid_imm     <= dec_imm;
            skid_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_imm_decoder_pipe.sv
// Testbench for imm_decoder_pipe: table-driven decode vectors streamed one per
// cycle, plus directed sequences for backpressure, flush, reset and XLEN=64.
module tb_imm_decoder_pipe;

    localparam logic [2:0] I_TYPE = 3'd0;
    localparam logic [2:0] S_TYPE = 3'd1;
    localparam logic [2:0] B_TYPE = 3'd2;
    localparam logic [2:0] J_TYPE = 3'd3;
    localparam logic [2:0] U_TYPE = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic [31:0] inst;
    logic        auto_mode;
    logic [2:0]  imm_sel;
    logic        ready_in;

    logic        ready32, valid32, ill32;
    logic [31:0] imm32;
    logic        ready64, valid64, ill64;
    logic [63:0] imm64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_decoder_pipe #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in),
        .ready_o(ready32), .inst_i(inst), .auto_i(auto_mode), .ImmSel_i(imm_sel),
        .valid_o(valid32), .ready_i(ready_in), .imm_o(imm32), .illegal_o(ill32)
    );

    imm_decoder_pipe #(.XLEN(64)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in),
        .ready_o(ready64), .inst_i(inst), .auto_i(auto_mode), .ImmSel_i(imm_sel),
        .valid_o(valid64), .ready_i(ready_in), .imm_o(imm64), .illegal_o(ill64)
    );

    typedef struct {
        string       name;
        logic        auto_m;
        logic [2:0]  sel;
        logic [31:0] inst;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic a, input logic [2:0] s, input logic [31:0] w);
        valid_in  = v;
        auto_mode = a;
        imm_sel   = s;
        inst      = w;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle32(input string name);
        check({name, " valid"}, 64'(valid32), 64'd0);
        check({name, " imm"}, 64'(imm32), 64'd0);
        check({name, " ready"}, 64'(ready32), 64'd1);
        check({name, " ill"}, 64'(ill32), 64'd0);
    endtask

    initial begin
        // Manual mode vectors.
        vecs.push_back('{"man I addi -1",   1'b0, I_TYPE, 32'hFFF00093, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"man S sw 8",      1'b0, S_TYPE, 32'h0020A423, 32'h00000008, 1'b0});
        vecs.push_back('{"man B -4",        1'b0, B_TYPE, 32'hFE000EE3, 32'hFFFFFFFC, 1'b0});
        vecs.push_back('{"man J 0x800",     1'b0, J_TYPE, 32'h001000EF, 32'h00000800, 1'b0});
        vecs.push_back('{"man U lui",       1'b0, U_TYPE, 32'h123450B7, 32'h12345000, 1'b0});
        vecs.push_back('{"man bad sel",     1'b0, 3'd7,   32'hFFF00093, 32'h00000000, 1'b0});
        vecs.push_back('{"man bad opcode",  1'b0, U_TYPE, 32'h0000007F, 32'h00000000, 1'b0});
        // Auto mode vectors, test-plan order first.
        vecs.push_back('{"auto S",          1'b1, 3'd7,   32'h0020A423, 32'h00000008, 1'b0});
        vecs.push_back('{"auto B",          1'b1, 3'd7,   32'hFE000EE3, 32'hFFFFFFFC, 1'b0});
        vecs.push_back('{"auto J",          1'b1, 3'd7,   32'h001000EF, 32'h00000800, 1'b0});
        vecs.push_back('{"auto U lui",      1'b1, 3'd7,   32'h123450B7, 32'h12345000, 1'b0});
        vecs.push_back('{"auto zimm",       1'b1, 3'd7,   32'h3002D073, 32'h00000005, 1'b0});
        vecs.push_back('{"auto illegal 0",  1'b1, I_TYPE, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{"auto addi",       1'b1, 3'd7,   32'hFFF00093, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"auto slli 31",    1'b1, 3'd7,   32'h01F09093, 32'h0000001F, 1'b0});
        vecs.push_back('{"auto srai 3",     1'b1, 3'd7,   32'h4030D093, 32'h00000003, 1'b0});
        vecs.push_back('{"auto lw -2048",   1'b1, 3'd7,   32'h80002083, 32'hFFFFF800, 1'b0});
        vecs.push_back('{"auto jalr -4",    1'b1, 3'd7,   32'hFFC08067, 32'hFFFFFFFC, 1'b0});
        vecs.push_back('{"auto auipc",      1'b1, 3'd7,   32'hFFFFF117, 32'hFFFFF000, 1'b0});
        vecs.push_back('{"auto add",        1'b1, 3'd7,   32'h002081B3, 32'h00000000, 1'b0});
        vecs.push_back('{"auto fence",      1'b1, 3'd7,   32'h0FF0000F, 32'h00000000, 1'b0});
        vecs.push_back('{"auto csrrw",      1'b1, 3'd7,   32'h30029073, 32'h00000000, 1'b0});
        vecs.push_back('{"auto ecall",      1'b1, 3'd7,   32'h00000073, 32'h00000000, 1'b0});
        vecs.push_back('{"auto illegal 7f", 1'b1, 3'd7,   32'hFFFFFFFF, 32'h00000000, 1'b1});

        // Reset state.
        rst_n    = 1'b0;
        flush    = 1'b0;
        ready_in = 1'b1;
        drive(1'b0, 1'b0, I_TYPE, 32'h0);
        tick();
        tick();
        check_idle32("reset");
        rst_n = 1'b1;
        tick();

        // Back-to-back stream, one result per cycle with ready_i high.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].auto_m, vecs[i].sel, vecs[i].inst);
            tick();
            check({vecs[i].name, " valid"}, 64'(valid32), 64'd1);
            check({vecs[i].name, " imm"}, 64'(imm32), 64'(vecs[i].imm));
            check({vecs[i].name, " ill"}, 64'(ill32), 64'(vecs[i].ill));
        end
        drive(1'b0, 1'b0, I_TYPE, 32'h0);
        tick();
        check_idle32("drain");

        // Backpressure: three offered, two accepted, then drained in order.
        ready_in = 1'b0;
        drive(1'b1, 1'b0, I_TYPE, 32'h00100093);
        tick();
        check("bp first valid", 64'(valid32), 64'd1);
        check("bp first imm", 64'(imm32), 64'd1);
        check("bp ready after 1", 64'(ready32), 64'd1);
        drive(1'b1, 1'b0, I_TYPE, 32'h00200093);
        tick();
        check("bp ready after 2", 64'(ready32), 64'd0);
        check("bp imm held", 64'(imm32), 64'd1);
        drive(1'b1, 1'b0, I_TYPE, 32'h00300093);
        tick();
        check("bp ready still 0", 64'(ready32), 64'd0);
        check("bp imm stable", 64'(imm32), 64'd1);
        drive(1'b0, 1'b0, I_TYPE, 32'h0);
        ready_in = 1'b1;
        tick();
        check("bp second valid", 64'(valid32), 64'd1);
        check("bp second imm", 64'(imm32), 64'd2);
        check("bp ready back", 64'(ready32), 64'd1);
        tick();
        check_idle32("bp third dropped");

        // Flush with two entries held and an instruction offered.
        ready_in = 1'b0;
        drive(1'b1, 1'b0, I_TYPE, 32'h00500093);
        tick();
        drive(1'b1, 1'b0, I_TYPE, 32'h00600093);
        tick();
        check("fl full", 64'(ready32), 64'd0);
        drive(1'b1, 1'b0, I_TYPE, 32'h00700093);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, I_TYPE, 32'h0);
        check_idle32("flush full");
        ready_in = 1'b1;
        tick();
        check_idle32("flush after");

        // Flush discards an input accepted in the same cycle.
        drive(1'b1, 1'b0, I_TYPE, 32'h00800093);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, I_TYPE, 32'h0);
        check_idle32("flush accept");
        tick();
        check_idle32("flush accept after");

        // Reset with two entries held.
        ready_in = 1'b0;
        drive(1'b1, 1'b0, I_TYPE, 32'h00900093);
        tick();
        drive(1'b1, 1'b1, I_TYPE, 32'h00000000);
        tick();
        check("rst full", 64'(ready32), 64'd0);
        drive(1'b0, 1'b0, I_TYPE, 32'h0);
        rst_n = 1'b0;
        tick();
        check_idle32("reset mid");
        rst_n    = 1'b1;
        ready_in = 1'b1;
        tick();
        check_idle32("reset mid after");

        // XLEN=64 sign extension of U and the wider shift amount.
        drive(1'b1, 1'b1, I_TYPE, 32'h800000B7);
        tick();
        check("x64 lui valid", 64'(valid64), 64'd1);
        check("x64 lui imm", imm64, 64'hFFFFFFFF80000000);
        check("x32 lui imm", 64'(imm32), 64'h0000000080000000);
        drive(1'b1, 1'b1, I_TYPE, 32'h03F09093);
        tick();
        check("x64 slli imm", imm64, 64'h000000000000003F);
        check("x32 slli imm", 64'(imm32), 64'h000000000000001F);
        drive(1'b1, 1'b0, I_TYPE, 32'h80002083);
        tick();
        check("x64 man I imm", imm64, 64'hFFFFFFFFFFFFF800);
        check("x64 ill", 64'(ill64), 64'd0);
        drive(1'b0, 1'b0, I_TYPE, 32'h0);
        tick();
        check("x64 idle valid", 64'(valid64), 64'd0);
        check("x64 idle imm", imm64, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
